iob_timer_alarm: RTL and testbench

- Compare/alarm stage that sits directly downstream of the timer's free-running 2*DATA_W counter.
- Consumes the live count every cycle and fires an interrupt when the count reaches a programmed compare value.
- Supports one-shot and periodic (auto-reload) modes, with overrun counting for unacknowledged periodic events.
- Feeds the peripheral's interrupt line and CSR status fields.

---
 rtl/iob_timer_alarm.sv | 167 ++++++++++++++++
 tb/tb_iob_timer_alarm.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/iob_timer_alarm.sv
// iob_timer_alarm
// ---------------------------------------------------------------------------
// Compare/alarm stage fed by the timer's free-running 2*DATA_W counter.
// Fires an interrupt when the live count reaches a programmed compare value,
// in one-shot or periodic (auto-reload) mode, and counts periodic fires that
// land while a previous interrupt is still pending.
//
// Optional feature (compile-time macro IOB_TIMER_ALARM_SNAPSHOT_EN):
//   defined   : match_time_o captures time_i on every fire.
//   undefined : no snapshot register; match_time_o is tied to 0.
//
// Ports:
//   clk_i         clock, all state updates on the rising edge
//   rst_n_i       synchronous active-low reset (overrides cke_i)
//   cke_i         clock enable; all state holds when low
//   time_i        live counter value (2*DATA_W)
//   cmp_i         compare value, loaded on arm_i
//   period_i      reload increment, loaded on arm_i
//   periodic_i    mode loaded on arm_i (0 one-shot, 1 periodic)
//   arm_i         pulse: load cmp/period/mode, enter ARMED, clear irq
//   disarm_i      pulse: go IDLE, clear irq and miss count
//   irq_ack_i     pulse: clear pending irq (FIRED -> IDLE)
//   irq_o         registered interrupt-pending flag
//   armed_o       high while ARMED
//   miss_o        saturating count of fires while irq_o already pending
//   match_time_o  time_i captured at the last fire
// ---------------------------------------------------------------------------
module iob_timer_alarm #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned MISS_W = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  cke_i,
   input  logic [2*DATA_W-1:0]   time_i,
   input  logic [2*DATA_W-1:0]   cmp_i,
   input  logic [2*DATA_W-1:0]   period_i,
   input  logic                  periodic_i,
   input  logic                  arm_i,
   input  logic                  disarm_i,
   input  logic                  irq_ack_i,
   output logic                  irq_o,
   output logic                  armed_o,
   output logic [MISS_W-1:0]     miss_o,
   output logic [2*DATA_W-1:0]   match_time_o
);

   localparam int unsigned TW = 2 * DATA_W;

   localparam logic [MISS_W-1:0] MissOne = MISS_W'(1);
   localparam logic [MISS_W-1:0] MissMax = {MISS_W{1'b1}};

   typedef enum logic [1:0] {
      StIdle,
      StArmed,
      StFired
   } state_e;

   state_e            state_q, state_d;
   logic [TW-1:0]     cmp_q, cmp_d;
   logic [TW-1:0]     period_q, period_d;
   logic              mode_q, mode_d;
   logic              irq_q, irq_d;
   logic [MISS_W-1:0] miss_q, miss_d;

   logic [TW-1:0]     diff;
   logic              match;
   logic              fire;

   // Wrap-safe compare: time is at or past cmp when the modular difference
   // lies in the lower half of the range.
   assign diff  = time_i - cmp_q;
   assign match = ~diff[TW-1];
   // Disarm and arm take priority over a fire in the same cycle.
   assign fire  = (state_q == StArmed) && match && !disarm_i && !arm_i;

   // ------------------------------------------------------------------------
   // Next-state logic. Priority: disarm > arm > fire > ack.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cmp_d    = cmp_q;
      period_d = period_q;
      mode_d   = mode_q;
      irq_d    = irq_q;
      miss_d   = miss_q;

      if (disarm_i) begin
         state_d = StIdle;
         irq_d   = 1'b0;
         miss_d  = '0;
      end else if (arm_i) begin
         state_d  = StArmed;
         cmp_d    = cmp_i;
         period_d = period_i;
         mode_d   = periodic_i;
         irq_d    = 1'b0;
      end else if (fire) begin
         irq_d = 1'b1;
         // An ack in the same cycle as a fire is consumed by the new event.
         if (irq_q && !irq_ack_i && (miss_q != MissMax)) begin
            miss_d = miss_q + MissOne;
         end
         if (!mode_q || (period_q == '0)) begin
            state_d = StFired;
         end else begin
            // One reload per cycle; a late counter catches up on
            // successive cycles.
            cmp_d = cmp_q + period_q;
         end
      end else if (irq_ack_i) begin
         irq_d = 1'b0;
         if (state_q == StFired) begin
            state_d = StIdle;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q  <= StIdle;
         cmp_q    <= '0;
         period_q <= '0;
         mode_q   <= 1'b0;
         irq_q    <= 1'b0;
         miss_q   <= '0;
      end else if (cke_i) begin
         state_q  <= state_d;
         cmp_q    <= cmp_d;
         period_q <= period_d;
         mode_q   <= mode_d;
         irq_q    <= irq_d;
         miss_q   <= miss_d;
      end
   end

   // ------------------------------------------------------------------------
   // Optional match-time snapshot for interrupt-latency measurement.
   // ------------------------------------------------------------------------
`ifdef IOB_TIMER_ALARM_SNAPSHOT_EN
   logic [TW-1:0] snap_q, snap_d;

   always_comb begin
      snap_d = snap_q;
      if (fire) begin
         snap_d = time_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         snap_q <= '0;
      end else if (cke_i) begin
         snap_q <= snap_d;
      end
   end

   assign match_time_o = snap_q;
`else
   assign match_time_o = '0;
`endif

   assign irq_o   = irq_q;
   assign armed_o = (state_q == StArmed);
   assign miss_o  = miss_q;

endmodule

// File: tb/tb_iob_timer_alarm.sv
// Self-checking bench for iob_timer_alarm (DATA_W=32, MISS_W=2 so that
// miss-counter saturation is reachable in a short run).
module tb_iob_timer_alarm;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned MISS_W = 2;

`ifdef IOB_TIMER_ALARM_SNAPSHOT_EN
   localparam bit Snap = 1'b1;
`else
   localparam bit Snap = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, cke, periodic, arm, disarm, ack;
   logic [63:0] time_v, cmp, period;
   logic        irq, armed;
   logic [1:0]  miss;
   logic [63:0] match_time;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   iob_timer_alarm #(
      .DATA_W(DATA_W),
      .MISS_W(MISS_W)
   ) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .cke_i       (cke),
      .time_i      (time_v),
      .cmp_i       (cmp),
      .period_i    (period),
      .periodic_i  (periodic),
      .arm_i       (arm),
      .disarm_i    (disarm),
      .irq_ack_i   (ack),
      .irq_o       (irq),
      .armed_o     (armed),
      .miss_o      (miss),
      .match_time_o(match_time)
   );

   typedef struct {
      string       nm;
      logic        rst_n, cke, arm, disarm, ack, periodic;
      logic [63:0] t, cmp, per;
      logic        e_irq, e_armed;
      logic [1:0]  e_miss;
      logic [63:0] e_mt;
   } vec_t;

   vec_t vecs[$];

   // Configuration used by add() for the vectors that follow.
   logic        g_rst = 1'b1, g_cke = 1'b1, g_mode = 1'b0;
   logic [63:0] g_cmp = '0, g_per = '0;

   task automatic add(input string nm, input logic [63:0] t, input logic a, d, k,
                      input logic e_irq, e_armed, input logic [1:0] e_miss,
                      input logic [63:0] e_mt);
      vec_t v;
      v.nm = nm; v.rst_n = g_rst; v.cke = g_cke; v.arm = a; v.disarm = d; v.ack = k;
      v.periodic = g_mode; v.t = t; v.cmp = g_cmp; v.per = g_per;
      v.e_irq = e_irq; v.e_armed = e_armed; v.e_miss = e_miss; v.e_mt = e_mt;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_all(input string nm, input logic e_irq, e_armed,
                            input logic [1:0] e_miss, input logic [63:0] e_mt);
      chk({nm, ".irq"}, 64'(irq), 64'(e_irq));
      chk({nm, ".armed"}, 64'(armed), 64'(e_armed));
      chk({nm, ".miss"}, 64'(miss), 64'(e_miss));
      chk({nm, ".match_time"}, match_time, Snap ? e_mt : 64'd0);
   endtask

   // One clock: drive at negedge, sample 1 time unit after the rising edge.
   task automatic cyc(input logic r, c, input logic [63:0] t, c_v, p_v, input logic m,
                      input logic a, d, k);
      @(negedge clk);
      rst_n = r; cke = c; time_v = t; cmp = c_v; period = p_v; periodic = m;
      arm = a; disarm = d; ack = k;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [63:0] mt;
      logic [63:0] tw;
      int          fires;
      logic        f;

      rst_n = 1'b0; cke = 1'b1; time_v = '0; cmp = '0; period = '0;
      periodic = 1'b0; arm = 1'b0; disarm = 1'b0; ack = 1'b0;

      // ---------------- build vector table ----------------
      g_rst = 1'b0;
      add("rst0", 0, 0, 0, 0, 0, 0, 0, 0);
      add("rst1", 0, 0, 0, 0, 0, 0, 0, 0);
      g_rst = 1'b1;

      // One-shot at 100.
      g_cmp = 100; g_per = 0; g_mode = 1'b0;
      add("os_arm", 90, 1, 0, 0, 0, 1, 0, 0);
      for (int t = 91; t <= 99; t++) add("os_wait", 64'(t), 0, 0, 0, 0, 1, 0, 0);
      add("os_fire", 100, 0, 0, 0, 1, 0, 0, 100);
      add("os_hold", 101, 0, 0, 0, 1, 0, 0, 100);
      add("os_ack", 102, 0, 0, 1, 0, 0, 0, 100);
      add("os_idle", 200, 0, 0, 0, 0, 0, 0, 100);

      // Periodic 50 + n*20, acknowledged one cycle after each fire.
      g_cmp = 50; g_per = 20; g_mode = 1'b1;
      mt = 100;
      add("per_arm", 45, 1, 0, 0, 0, 1, 0, mt);
      for (int t = 46; t <= 115; t++) begin
         f = (t == 50) || (t == 70) || (t == 90) || (t == 110);
         if (f) mt = 64'(t);
         add("per_ack", 64'(t), 0, 0, (t == 51) || (t == 71) || (t == 91) || (t == 111),
             f, 1, 0, mt);
      end

      // Same setup, never acknowledged: misses accumulate and saturate at 3.
      add("ovr_arm", 45, 1, 0, 0, 0, 1, 0, mt);
      fires = 0;
      for (int t = 46; t <= 135; t++) begin
         if (t >= 50 && ((t - 50) % 20) == 0) begin
            fires++;
            mt = 64'(t);
         end
         add("ovr", 64'(t), 0, 0, 0, fires > 0, 1,
             (fires <= 1) ? 2'd0 : ((fires - 1 >= 3) ? 2'd3 : 2'(fires - 1)), mt);
      end
      add("dis_ack", 136, 0, 1, 1, 0, 0, 0, mt);

      // Compare across the 64-bit wrap.
      g_cmp = 5; g_per = 0; g_mode = 1'b0;
      add("wrap_arm", 64'hFFFF_FFFF_FFFF_FFFD, 1, 0, 0, 0, 1, 0, mt);
      tw = 64'hFFFF_FFFF_FFFF_FFFE;
      for (int i = 0; i < 7; i++) begin
         add("wrap_wait", tw, 0, 0, 0, 0, 1, 0, mt);
         tw = tw + 64'd1;
      end
      add("wrap_fire", 5, 0, 0, 0, 1, 0, 0, 5);
      add("wrap_ack", 6, 0, 0, 1, 0, 0, 0, 5);

      // Compare value already in the past: fires on first ARMED cycle.
      g_cmp = 10;
      add("past_arm", 1000, 1, 0, 0, 0, 1, 0, 5);
      add("past_fire", 1001, 0, 0, 0, 1, 0, 0, 1001);
      add("past_ack", 1002, 0, 0, 1, 0, 0, 0, 1001);

      // Ack coinciding with a fire: fire wins, no miss counted.
      g_cmp = 2000; g_per = 10; g_mode = 1'b1;
      add("af_arm", 1999, 1, 0, 0, 0, 1, 0, 1001);
      add("af_fire", 2000, 0, 0, 0, 1, 1, 0, 2000);
      for (int t = 2001; t <= 2009; t++) add("af_pend", 64'(t), 0, 0, 0, 1, 1, 0, 2000);
      add("af_ackfire", 2010, 0, 0, 1, 1, 1, 0, 2010);
      add("af_pend2", 2011, 0, 0, 0, 1, 1, 0, 2010);
      add("af_miss", 2020, 0, 0, 0, 1, 1, 1, 2020);
      add("af_disarm", 2021, 0, 1, 0, 0, 0, 0, 2020);

      // ---------------- apply table ----------------
      foreach (vecs[i]) begin
         cyc(vecs[i].rst_n, vecs[i].cke, vecs[i].t, vecs[i].cmp, vecs[i].per,
             vecs[i].periodic, vecs[i].arm, vecs[i].disarm, vecs[i].ack);
         check_all(vecs[i].nm, vecs[i].e_irq, vecs[i].e_armed, vecs[i].e_miss, vecs[i].e_mt);
      end

      // ---------------- cke gating across a match ----------------
      cyc(1, 1, 2995, 3000, 0, 0, 1, 0, 0);
      check_all("cke_arm", 0, 1, 0, 2020);
      for (int t = 3000; t <= 3003; t++) begin
         cyc(1, 0, 64'(t), 0, 0, 0, 0, 0, 0);
         check_all("cke_off", 0, 1, 0, 2020);
      end
      cyc(1, 1, 3004, 0, 0, 0, 0, 0, 0);
      check_all("cke_fire", 1, 0, 0, 3004);
      cyc(1, 0, 3005, 0, 0, 0, 0, 0, 1);
      check_all("cke_ack_gated", 1, 0, 0, 3004);
      cyc(0, 0, 3006, 0, 0, 0, 0, 0, 0);
      check_all("rst_cke_off", 0, 0, 0, 0);

      // ---------------- periodic catch-up, one fire per cycle ----------------
      cyc(1, 1, 100, 90, 5, 1, 1, 0, 0);
      check_all("cu_arm", 0, 1, 0, 0);
      cyc(1, 1, 100, 0, 0, 0, 0, 0, 0);
      check_all("cu_fire90", 1, 1, 0, 100);
      cyc(1, 1, 100, 0, 0, 0, 0, 0, 0);
      check_all("cu_fire95", 1, 1, 1, 100);
      cyc(1, 1, 100, 0, 0, 0, 0, 0, 0);
      check_all("cu_fire100", 1, 1, 2, 100);
      cyc(1, 1, 100, 0, 0, 0, 0, 0, 0);
      check_all("cu_caught_up", 1, 1, 2, 100);
      cyc(1, 1, 101, 0, 0, 0, 0, 0, 1);
      check_all("cu_ack", 0, 1, 2, 100);
      cyc(1, 1, 105, 0, 0, 0, 0, 0, 0);
      check_all("cu_fire105", 1, 1, 2, 105);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
